sum_stream_feeder: RTL and testbench
====================================

# sum_stream_feeder

Transmit-side companion of the sumItUp accumulator thread. A host loads a list of nonzero 16-bit words, then pulses `start`. The block drives the accumulator's `go_l`/`inA` handshake: one word per cycle, then a zero terminator. It captures the accumulator's `sum`, `done` and `error` on the terminator cycle, and checks them against its own locally computed 17-bit total.

## Interface
- `DEPTH`, default 8: word buffer entries, at least 2.
- `ck`  in  1: clock; all state updates on the rising edge.
- `reset_l`  in  1: reset, asynchronous, active-low.
- `wr_en`  in  1: host write strobe.
- `wr_data`  in  16: word to append.
- `start`  in  1: start-burst pulse, sampled in IDLE only.
- `count`  out  $clog2(DEPTH+1): stored word count.
- `full`  out  1: `count == DEPTH`.
- `busy`  out  1: high in SEND or TERM.
- `result_valid`  out  1: result fields valid; held until the next accepted `start`.
- `result_sum`  out  16: accumulator `sum` captured on the terminator cycle.
- `result_err`  out  1: accumulator `error` captured on the terminator cycle.
- `result_fault`  out  1: accumulator response disagrees with the local check.
- `go_l`  out  1: to accumulator, active-low go.
- `inA`  out  16: to accumulator, data word.
- `done_in`  in  1: from accumulator `done`.
- `error_in`  in  1: from accumulator `error`.
- `sum_in`  in  16: from accumulator `sum`.

## Operation
- **States:** IDLE, SEND, TERM.
- **Buffer:** DEPTH×16 array, write pointer = `count`, read pointer `rp`.
- **Writes:** accepted only in IDLE with `~full` and `wr_data != 0`.
  - Zero words are discarded, because a zero would terminate the stream early.
  - Writes in SEND/TERM, or while full, are ignored.
- **IDLE → SEND:** on `start` with `count != 0`.
  - On that edge: `rp <= 0`, local accumulator `acc[16:0] <= 0`, `result_valid <= 0`.
  - `start` with `count == 0` is ignored.
  - `start` and `wr_en` in the same IDLE cycle: `start` wins and the write is dropped.
- **SEND:**
  - Drives `go_l = 0`, `inA = buf[rp]`.
  - Each edge: `acc <= acc + {1'b0, buf[rp]}`, saturating bit 16 (once set it stays set); `rp <= rp + 1`.
  - When `rp == count-1`, go to TERM.
- **TERM (exactly one cycle):**
  - Drives `go_l = 0`, `inA = 0`.
  - On the edge: `result_sum <= sum_in`, `result_err <= error_in`, `result_valid <= 1`, `count <= 0` (buffer consumed), go to IDLE.
  - `result_fault <= (error_in != acc[16]) | (done_in != ~acc[16]) | (~acc[16] & (sum_in != acc[15:0]))`.
- **IDLE:** drives `go_l = 1`, `inA = 0`. The high `go_l` clears the accumulator's error latch.
- **Arithmetic:** unsigned. `acc[16]` marks an overflow at any point in the burst. Overflow is not a fault by itself; `result_err = 1` with `result_fault = 0` is a legal outcome.
- **Output timing:** `go_l`/`inA` are combinational from state and `rp`. All result outputs are registered.

## Timing
- **Reset values:**
  - State IDLE, `go_l = 1`, `inA = 0`, `count = 0`, `full = 0`, `busy = 0`.
  - `result_valid = 0`, `result_sum = 0`, `result_err = 0`, `result_fault = 0`, `rp = 0`, `acc = 0`.
- **Burst timing:** `start` sampled at edge k, `count = N`.
  - Cycles k+1 … k+N: words 0 … N-1 on `inA` with `go_l = 0`.
  - Cycle k+N+1: terminator (`inA = 0`, `go_l = 0`); `done_in`/`error_in`/`sum_in` sampled at its closing edge.
  - Cycle k+N+2: `result_valid = 1`, `go_l = 1`, `busy = 0`, IDLE.
  - Burst length is N+1 cycles of `go_l` low.
- **Continuity:** `go_l` stays continuously low through SEND and TERM, with no gap.
- **Back-to-back:** a new burst may be loaded and started from cycle k+N+2. The accumulator sees at least one `go_l = 1` cycle between bursts.
- **Reset mid-burst:** all registers return to reset values immediately. `go_l = 1` asynchronously. The buffer contents are lost (`count = 0`).
- **N = DEPTH:** `full = 1` until the TERM edge, then 0.

## Test plan
- **Single word:**
  - Stimulus: write 5, start.
  - Required: `go_l` low 2 cycles with `inA` = 5 then 0; `result_sum = 5`, `result_err = 0`, `result_fault = 0`.
- **Full buffer:**
  - Stimulus: DEPTH=8, write 1..8, start.
  - Required: `inA` = 1..8 then 0 over 9 cycles; `result_sum = 36`, `result_valid` rises at k+10.
- **Overflow:**
  - Stimulus: write 0xFFF0, 0x0020, start.
  - Required: `result_err = 1`, `result_fault = 0`, `done_in` low on the terminator cycle.
- **Filtering and start gating:**
  - Stimulus: write 0, then 3; writes during `busy`; a 9th write when full; start with `count = 0`.
  - Required: zero dropped (`count = 1`), busy/full writes ignored, empty start produces no `go_l` activity.
- **Fault detection:**
  - Stimulus: accumulator model forced to return `sum_in` off by one.
  - Required: `result_fault = 1`, `result_sum` = the returned value.
- **Reset mid-burst:**
  - Stimulus: assert `reset_l` low during SEND word 2 of 4.
  - Required: `go_l = 1` immediately, `count = 0`, `result_valid = 0`; a subsequent load/start works normally.

Source files
------------

// File: rtl/sum_stream_feeder.sv
// sum_stream_feeder: buffers nonzero host words, streams them to the sumItUp
// accumulator over the go_l/inA handshake, closes each burst with a zero
// terminator, and checks the accumulator's reply against a local 17-bit total.
module sum_stream_feeder #(
    parameter int DEPTH = 8
) (
    input  logic                       ck,
    input  logic                       reset_l,
    input  logic                       wr_en,
    input  logic [15:0]                wr_data,
    input  logic                       start,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       busy,
    output logic                       result_valid,
    output logic [15:0]                result_sum,
    output logic                       result_err,
    output logic                       result_fault,
    output logic                       go_l,
    output logic [15:0]                inA,
    input  logic                       done_in,
    input  logic                       error_in,
    input  logic [15:0]                sum_in
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_TERM = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [15:0]   buf_r [DEPTH];
    logic [CW-1:0] count_r;
    logic [AW-1:0] rp_r;
    logic [16:0]   acc_r;
    logic          result_valid_r;
    logic [15:0]   result_sum_r;
    logic          result_err_r;
    logic          result_fault_r;

    logic          full_s;
    logic          start_ok_s;
    logic          wr_ok_s;
    logic          last_s;
    logic [15:0]   word_s;
    logic [16:0]   sum17_s;
    logic [16:0]   acc_s;
    logic          fault_s;

    // Decode control conditions, next-state and the accumulator handshake
    always_comb begin
        state_s    = state_r;
        go_l       = 1'b1;
        inA        = 16'h0000;
        full_s     = (count_r == CW'(DEPTH));
        start_ok_s = (state_r == ST_IDLE) && start && (count_r != {CW{1'b0}});
        // an accepted start takes priority over a write in the same cycle
        wr_ok_s    = (state_r == ST_IDLE) && wr_en && !full_s &&
                     (wr_data != 16'h0000) && !start_ok_s;
        word_s     = buf_r[rp_r];
        last_s     = (CW'(rp_r) == (count_r - CW'(1)));
        sum17_s    = {1'b0, acc_r[15:0]} + {1'b0, word_s};
        // bit 16 is sticky: any overflow during the burst is remembered
        acc_s      = {acc_r[16] | sum17_s[16], sum17_s[15:0]};
        fault_s    = (error_in != acc_r[16]) | (done_in != ~acc_r[16]) |
                     (~acc_r[16] & (sum_in != acc_r[15:0]));
        case (state_r)
            ST_IDLE: begin
                go_l = 1'b1;
                inA  = 16'h0000;
                if (start_ok_s) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                go_l = 1'b0;
                inA  = word_s;
                if (last_s) begin
                    state_s = ST_TERM;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_TERM: begin
                go_l    = 1'b0;
                inA     = 16'h0000;
                state_s = ST_IDLE;
            end
            default: begin
                go_l    = 1'b1;
                inA     = 16'h0000;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointers, local total and registered result fields
    always_ff @(posedge ck or negedge reset_l) begin
        if (!reset_l) begin
            state_r        <= ST_IDLE;
            count_r        <= {CW{1'b0}};
            rp_r           <= {AW{1'b0}};
            acc_r          <= 17'h00000;
            result_valid_r <= 1'b0;
            result_sum_r   <= 16'h0000;
            result_err_r   <= 1'b0;
            result_fault_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        rp_r           <= {AW{1'b0}};
                        acc_r          <= 17'h00000;
                        result_valid_r <= 1'b0;
                    end else if (wr_ok_s) begin
                        count_r <= count_r + CW'(1);
                    end
                end
                ST_SEND: begin
                    acc_r <= acc_s;
                    rp_r  <= rp_r + AW'(1);
                end
                ST_TERM: begin
                    result_sum_r   <= sum_in;
                    result_err_r   <= error_in;
                    result_fault_r <= fault_s;
                    result_valid_r <= 1'b1;
                    count_r        <= {CW{1'b0}};
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Word storage; contents are only meaningful below count_r
    always_ff @(posedge ck) begin
        if (wr_ok_s) begin
            buf_r[AW'(count_r)] <= wr_data;
        end
    end

    assign count        = count_r;
    assign full         = full_s;
    assign busy         = (state_r != ST_IDLE);
    assign result_valid = result_valid_r;
    assign result_sum   = result_sum_r;
    assign result_err   = result_err_r;
    assign result_fault = result_fault_r;

endmodule

// File: tb/tb_sum_stream_feeder.sv
// Self-checking bench for sum_stream_feeder with a behavioural sumItUp model.
module tb_sum_stream_feeder;

    logic        ck = 1'b0;
    logic        reset_l;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        start;
    logic [3:0]  count;
    logic        full;
    logic        busy;
    logic        result_valid;
    logic [15:0] result_sum;
    logic        result_err;
    logic        result_fault;
    logic        go_l;
    logic [15:0] inA;
    logic        done_in;
    logic        error_in;
    logic [15:0] sum_in;

    int checks   = 0;
    int failures = 0;

    sum_stream_feeder #(.DEPTH(8)) dut (
        .ck(ck), .reset_l(reset_l), .wr_en(wr_en), .wr_data(wr_data),
        .start(start), .count(count), .full(full), .busy(busy),
        .result_valid(result_valid), .result_sum(result_sum),
        .result_err(result_err), .result_fault(result_fault),
        .go_l(go_l), .inA(inA), .done_in(done_in), .error_in(error_in),
        .sum_in(sum_in)
    );

    always #5 ck = ~ck;

    // Behavioural sumItUp accumulator: sums while go_l low, done on zero word
    logic [15:0] m_sum;
    logic        m_err;
    logic [15:0] fault_off = 16'h0000;
    always @(posedge ck) begin
        if (go_l) begin
            m_sum <= 16'h0000;
            m_err <= 1'b0;
        end else if (inA != 16'h0000) begin
            m_sum <= m_sum + inA;
            m_err <= m_err | (({1'b0, m_sum} + {1'b0, inA}) > 17'h0FFFF);
        end
    end
    assign sum_in   = m_sum + fault_off;
    assign error_in = m_err;
    assign done_in  = ~go_l & (inA == 16'h0000) & ~m_err;

    // Burst capture state
    logic [15:0] obs_q[$];
    logic [3:0]  cnt_q[$];
    logic        full_q[$];
    logic [15:0] wq[$];
    int          valid_idx;
    logic        term_done;
    logic        busy_bad;

    function automatic int total_of();
        int t = 0;
        foreach (wq[i]) t += int'(wq[i]);
        return t;
    endfunction

    task automatic write_word(input logic [15:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge ck);
        wr_en = 1'b0; wr_data = 16'h0000;
    endtask

    task automatic load_wq();
        foreach (wq[i]) write_word(wq[i]);
    endtask

    // Pulse start, then record inA/count/full for every go_l-low cycle
    task automatic run_burst(input int budget, input bit wr_during);
        obs_q.delete(); cnt_q.delete(); full_q.delete();
        valid_idx = -1; term_done = 1'b1; busy_bad = 1'b0;
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (go_l == 1'b0) begin
                obs_q.push_back(inA);
                cnt_q.push_back(count);
                full_q.push_back(full);
                if (!busy || result_valid) busy_bad = 1'b1;
                if (inA == 16'h0000) term_done = done_in;
            end else begin
                valid_idx = i;
                break;
            end
            if (wr_during) begin wr_en = 1'b1; wr_data = 16'h0007; end
            @(negedge ck);
        end
        wr_en = 1'b0; wr_data = 16'h0000;
    endtask

    task automatic test_reset();
        reset_l = 1'b0; wr_en = 1'b0; wr_data = 16'h0000; start = 1'b0;
        repeat (2) @(negedge ck);
        checks++; if ({go_l, inA} !== {1'b1, 16'h0000}) begin failures++; $display("FAIL reset_handshake got=%h/%h exp=1/0000", go_l, inA); end
        checks++; if ({count, full, busy} !== 6'b0) begin failures++; $display("FAIL reset_status got=%0d/%b/%b exp=0/0/0", count, full, busy); end
        checks++; if ({result_valid, result_sum, result_err, result_fault} !== 19'b0) begin failures++; $display("FAIL reset_result got=%b/%h/%b/%b exp=0", result_valid, result_sum, result_err, result_fault); end
        reset_l = 1'b1;
        @(negedge ck);
    endtask

    task automatic test_single_word();
        write_word(16'd5);
        run_burst(20, 1'b0);
        checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL single_len got=%0d exp=2", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== 16'd5 || obs_q[1] !== 16'd0) begin failures++; $display("FAIL single_seq got=%h,%h exp=0005,0000", obs_q[0], obs_q[1]); end
        end
        checks++; if (valid_idx !== 2 || result_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0d/%b exp=2/1", valid_idx, result_valid); end
        checks++; if ({result_sum, result_err, result_fault} !== {16'd5, 1'b0, 1'b0}) begin failures++; $display("FAIL single_result got=%h/%b/%b exp=0005/0/0", result_sum, result_err, result_fault); end
        checks++; if (busy_bad) begin failures++; $display("FAIL single_busy got=bad exp=busy_high_valid_low"); end
    endtask

    task automatic test_full_buffer();
        for (int i = 1; i <= 8; i++) write_word(16'(i));
        checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL full_load got=%0d/%b exp=8/1", count, full); end
        run_burst(30, 1'b0);
        checks++; if (obs_q.size() !== 9) begin failures++; $display("FAIL full_len got=%0d exp=9", obs_q.size()); end
        else begin
            for (int i = 0; i < 9; i++) begin
                checks++; if (obs_q[i] !== ((i < 8) ? 16'(i + 1) : 16'h0000) || full_q[i] !== 1'b1) begin failures++; $display("FAIL full_seq[%0d] got=%h/%b exp=%h/1", i, obs_q[i], full_q[i], (i < 8) ? i + 1 : 0); end
            end
        end
        checks++; if (valid_idx !== 9) begin failures++; $display("FAIL full_valid_time got=%0d exp=9", valid_idx); end
        checks++; if (result_sum !== 16'd36 || result_fault !== 1'b0) begin failures++; $display("FAIL full_result got=%0d/%b exp=36/0", result_sum, result_fault); end
        checks++; if (count !== 4'd0 || full !== 1'b0) begin failures++; $display("FAIL full_after got=%0d/%b exp=0/0", count, full); end
    endtask

    task automatic test_overflow();
        write_word(16'hFFF0); write_word(16'h0020);
        run_burst(20, 1'b0);
        checks++; if ({result_err, result_fault} !== 2'b10) begin failures++; $display("FAIL ovf_flags got=%b/%b exp=1/0", result_err, result_fault); end
        checks++; if (term_done !== 1'b0) begin failures++; $display("FAIL ovf_done got=%b exp=0", term_done); end
        checks++; if (result_sum !== 16'h0010 || result_valid !== 1'b1) begin failures++; $display("FAIL ovf_sum got=%h/%b exp=0010/1", result_sum, result_valid); end
    endtask

    task automatic test_filtering();
        write_word(16'h0000);
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL filt_zero got=%0d exp=0", count); end
        write_word(16'd3);
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL filt_one got=%0d exp=1", count); end
        run_burst(20, 1'b1);
        foreach (cnt_q[i]) begin
            checks++; if (cnt_q[i] !== 4'd1) begin failures++; $display("FAIL filt_busy_wr[%0d] got=%0d exp=1", i, cnt_q[i]); end
        end
        checks++; if (obs_q.size() !== 2 || count !== 4'd0 || result_sum !== 16'd3) begin failures++; $display("FAIL filt_burst got=%0d/%0d/%0d exp=2/0/3", obs_q.size(), count, result_sum); end
        for (int i = 0; i < 9; i++) write_word(16'h0100 + 16'(i));
        checks++; if (count !== 4'd8 || full !== 1'b1) begin failures++; $display("FAIL filt_ninth got=%0d/%b exp=8/1", count, full); end
        run_burst(30, 1'b0);
        checks++; if (obs_q.size() !== 9) begin failures++; $display("FAIL filt_ninth_len got=%0d exp=9", obs_q.size()); end
        else begin
            checks++; if (obs_q[7] !== 16'h0107) begin failures++; $display("FAIL filt_ninth_last got=%h exp=0107", obs_q[7]); end
        end
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (go_l !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b1) begin failures++; $display("FAIL empty_start[%0d] got=%b/%b/%b exp=1/0/1", i, go_l, busy, result_valid); end
            @(negedge ck);
        end
    endtask

    task automatic test_fault();
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(16'($urandom_range(1, 4000)));
        load_wq();
        fault_off = 16'h0001;
        run_burst(20, 1'b0);
        fault_off = 16'h0000;
        checks++; if (result_fault !== 1'b1 || result_err !== 1'b0) begin failures++; $display("FAIL fault_flag got=%b/%b exp=1/0", result_fault, result_err); end
        checks++; if (result_sum !== 16'(total_of() + 1)) begin failures++; $display("FAIL fault_sum got=%h exp=%h", result_sum, 16'(total_of() + 1)); end
    endtask

    task automatic test_reset_mid_burst();
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(16'($urandom_range(1, 9000)));
        load_wq();
        start = 1'b1;
        @(negedge ck);
        start = 1'b0;
        @(negedge ck);
        checks++; if (go_l !== 1'b0 || inA !== wq[1]) begin failures++; $display("FAIL mid_word2 got=%b/%h exp=0/%h", go_l, inA, wq[1]); end
        #2 reset_l = 1'b0;
        #1;
        checks++; if (go_l !== 1'b1 || inA !== 16'h0000 || busy !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%h/%b exp=1/0000/0", go_l, inA, busy); end
        checks++; if (count !== 4'd0 || result_valid !== 1'b0 || result_sum !== 16'h0000 || result_fault !== 1'b0) begin failures++; $display("FAIL mid_regs got=%0d/%b/%h/%b exp=0/0/0000/0", count, result_valid, result_sum, result_fault); end
        @(negedge ck);
        reset_l = 1'b1;
        @(negedge ck);
        wq.delete();
        wq.push_back(16'h1234); wq.push_back(16'h0101);
        load_wq();
        run_burst(20, 1'b0);
        checks++; if (obs_q.size() !== 3 || result_sum !== 16'h1335 || result_fault !== 1'b0) begin failures++; $display("FAIL mid_recover got=%0d/%h/%b exp=3/1335/0", obs_q.size(), result_sum, result_fault); end
    endtask

    task automatic test_back_to_back();
        write_word(16'h0AAA);
        run_burst(20, 1'b0);
        write_word(16'h0055);
        write_word(16'h0022);
        run_burst(20, 1'b0);
        checks++; if (obs_q.size() !== 3) begin failures++; $display("FAIL b2b_len got=%0d exp=3", obs_q.size()); end
        else begin
            checks++; if (obs_q[0] !== 16'h0055 || obs_q[1] !== 16'h0022 || obs_q[2] !== 16'h0000) begin failures++; $display("FAIL b2b_seq got=%h,%h,%h exp=0055,0022,0000", obs_q[0], obs_q[1], obs_q[2]); end
        end
        checks++; if (result_sum !== 16'h0077 || result_valid !== 1'b1 || result_fault !== 1'b0) begin failures++; $display("FAIL b2b_result got=%h/%b/%b exp=0077/1/0", result_sum, result_valid, result_fault); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int n;
            int tot;
            n = $urandom_range(1, 8);
            wq.delete();
            for (int i = 0; i < n; i++)
                wq.push_back((it % 2 == 0) ? 16'($urandom_range(1, 7000)) : 16'($urandom_range(1, 65535)));
            load_wq();
            run_burst(30, 1'b0);
            tot = total_of();
            checks++; if (obs_q.size() !== n + 1) begin failures++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, obs_q.size(), n + 1); end
            else begin
                for (int i = 0; i <= n; i++) begin
                    checks++; if (obs_q[i] !== ((i < n) ? wq[i] : 16'h0000)) begin failures++; $display("FAIL rand%0d_word[%0d] got=%h exp=%h", it, i, obs_q[i], (i < n) ? wq[i] : 16'h0000); end
                end
            end
            checks++; if (valid_idx !== n + 1) begin failures++; $display("FAIL rand%0d_time got=%0d exp=%0d", it, valid_idx, n + 1); end
            checks++; if (result_sum !== 16'(tot) || result_err !== (tot > 65535) || result_fault !== 1'b0) begin failures++; $display("FAIL rand%0d_result got=%h/%b/%b exp=%h/%b/0", it, result_sum, result_err, result_fault, 16'(tot), tot > 65535); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_buffer();
        test_overflow();
        test_filtering();
        test_fault();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
